// File: rtl/modinv_2237_pkg.sv
// Shared constants and types for the mod-2237 Fermat inverter.
// Exponent 2235 = P-2; Barrett reduction uses k = 24, mu = floor(2^24 / P).
package modinv_2237_pkg;

  localparam int unsigned P         = 2237;
  localparam int unsigned W         = 12;
  localparam logic [11:0] EXP       = 12'd2235;
  localparam int unsigned BARRETT_K = 24;
  localparam int unsigned MU        = 7499;
  localparam int unsigned MU_W      = 13;
  localparam int unsigned PROD_W    = 2 * W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SQR  = 2'd1,
    ST_MUL  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/modinv_2237_modmul.sv
// Combinational x*y mod 2237: full product, Barrett quotient estimate,
// then at most two corrective subtractions (estimate is low by at most 2).
module modmul_2237
  import modinv_2237_pkg::*;
(
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic [W-1:0] r
);

  localparam int unsigned QM_W = PROD_W + MU_W;

  logic [PROD_W-1:0] prod;
  logic [QM_W-1:0]   prod_mu;
  logic [MU_W-1:0]   q;
  logic [PROD_W-1:0] qp;
  logic [PROD_W-1:0] rem0;
  logic [PROD_W-1:0] rem1;
  logic [PROD_W-1:0] rem2;

  always_comb begin
    prod    = PROD_W'(x) * PROD_W'(y);
    prod_mu = QM_W'(prod) * QM_W'(MU);
    q       = prod_mu[QM_W-1:BARRETT_K];
    qp      = PROD_W'(q) * PROD_W'(P);
    rem0    = prod - qp;
    rem1    = (rem0 >= PROD_W'(P)) ? rem0 - PROD_W'(P) : rem0;
    rem2    = (rem1 >= PROD_W'(P)) ? rem1 - PROD_W'(P) : rem1;
    r       = rem2[W-1:0];
  end

endmodule

// File: rtl/modinv_2237.sv
// Modular inverse mod 2237 by square-and-multiply of a^2235, one step per cycle.
// Handshake: a transfer happens on a rising edge where valid && ready are both 1.
module modinv_2237
  import modinv_2237_pkg::*;
#(
  parameter int P = 2237,
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] din_a,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] dout_r,
  output logic         err_o,
  output logic [1:0]   dbg_state
);

  state_t       state;
  logic [W-1:0] a_r;
  logic [W-1:0] acc;
  logic [3:0]   idx;
  logic [W-1:0] a_next;
  logic [W-1:0] mm_y;
  logic [W-1:0] mm_r;

  assign dbg_state = state;
  assign a_next    = (din_a >= W'(P)) ? din_a - W'(P) : din_a;
  // SQR multiplies acc by itself, MUL multiplies acc by the reduced operand.
  assign mm_y      = (state == ST_MUL) ? a_r : acc;

  modmul_2237 u_modmul (
    .x (acc),
    .y (mm_y),
    .r (mm_r)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      dout_r    <= '0;
      err_o     <= 1'b0;
      a_r       <= '0;
      acc       <= '0;
      idx       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_r      <= a_next;
            acc      <= a_next;
            idx      <= 4'd10;
            in_ready <= 1'b0;
            state    <= ST_SQR;
          end
        end
        ST_SQR: begin
          acc <= mm_r;
          if (EXP[idx]) begin
            state <= ST_MUL;
          end else if (idx == 4'd0) begin
            state     <= ST_DONE;
            out_valid <= 1'b1;
            dout_r    <= (a_r == '0) ? '0 : mm_r;
            err_o     <= (a_r == '0);
          end else begin
            idx <= idx - 4'd1;
          end
        end
        ST_MUL: begin
          acc <= mm_r;
          if (idx == 4'd0) begin
            state     <= ST_DONE;
            out_valid <= 1'b1;
            dout_r    <= (a_r == '0) ? '0 : mm_r;
            err_o     <= (a_r == '0);
          end else begin
            idx   <= idx - 4'd1;
            state <= ST_SQR;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_modinv_2237.sv
// Directed bench for modinv_2237: known inverses, latency, backpressure,
// mid-operation reset and a full 1..2236 inverse sweep.
module tb_modinv_2237;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [11:0] din_a = '0;
  logic        in_ready;
  logic        out_valid;
  logic [11:0] dout_r;
  logic        err_o;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  modinv_2237 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din_a     (din_a),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout_r    (dout_r),
    .err_o     (err_o),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_q(input string tag, input logic [31:0] got);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: got %0d expected <empty queue>", tag, got);
    end else begin
      e = exp_q.pop_front();
      check(tag, got, e);
    end
  endtask

  // Accepts one operand and waits (bounded) for out_valid; leaves result pending.
  task automatic do_op(input logic [11:0] d, output logic [11:0] r, output logic e);
    int lat;
    int w;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("accept_ready", in_ready, 1);
    in_valid = 1'b1;
    din_a    = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    din_a    = 12'($urandom_range(0, 4095));
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", lat, 17);
    r = dout_r;
    e = err_o;
  endtask

  task automatic handshake();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("hs_out_valid_low", out_valid, 0);
    check("hs_in_ready_high", in_ready, 1);
  endtask

  logic [11:0] vec_din [8] = '{12'd2, 12'd3, 12'd1, 12'd2236, 12'd2239, 12'd4, 12'd0, 12'd2237};
  logic [11:0] vec_inv [8] = '{12'd1119, 12'd746, 12'd1, 12'd2236, 12'd1119, 12'd1678, 12'd0, 12'd0};
  logic        vec_err [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    logic [11:0] r;
    logic        e;
    logic        seen;

    // reset
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_dout", dout_r, 0);
    check("rst_err", err_o, 0);
    check("rst_state", dbg_state, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rel_in_ready", in_ready, 1);
    check("rel_out_valid", out_valid, 0);

    // directed vectors
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(32'(vec_inv[i]));
      exp_q.push_back(32'(vec_err[i]));
      do_op(vec_din[i], r, e);
      check_q($sformatf("inv_%0d", vec_din[i]), 32'(r));
      check_q($sformatf("err_%0d", vec_din[i]), 32'(e));
      handshake();
    end

    // top of input range: 4095 reduces to 1858
    do_op(12'd4095, r, e);
    check("inv_4095_prod", (1858 * int'(r)) % 2237, 1);
    handshake();

    // backpressure: hold out_ready low for 20 cycles
    do_op(12'd3, r, e);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      check("hold_dout", dout_r, 746);
      check("hold_in_ready", in_ready, 0);
      check("hold_out_valid", out_valid, 1);
    end
    handshake();
    repeat (3) @(posedge clk);
    #1;
    check("single_hs", out_valid, 0);

    // reset during computation
    @(negedge clk);
    in_valid = 1'b1;
    din_a    = 12'd2;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_state", dbg_state, 0);
    check("midrst_dout", dout_r, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      seen = seen | out_valid;
    end
    check("midrst_no_output", seen, 0);
    do_op(12'd2, r, e);
    check("midrst_next_inv", r, 1119);
    handshake();

    // full sweep of nonzero residues
    for (int a = 1; a < 2237; a++) begin
      do_op(12'(a), r, e);
      check($sformatf("sweep_%0d", a), (a * int'(r)) % 2237, 1);
      handshake();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/modinv_2237.md
MODINV_2237 -- requirements
Module: modinv_2237

Interface
REQ-001 SHALL have parameter P, default 2237, prime modulus; values other than 2237 are unsupported.
REQ-002 SHALL have parameter W, default 12, residue width in bits.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous and active-low.
REQ-005 in_valid  input  1  din_a is valid this cycle.
REQ-006 in_ready  output  1  block can accept an operand.
REQ-007 din_a  input  W  operand, 0..4095.
REQ-008 out_valid  output  1  dout_r and err_o are valid.
REQ-009 out_ready  input  1  consumer accepts the result.
REQ-010 dout_r  output  W  modular inverse of din_a mod P.
REQ-011 err_o  output  1  operand is congruent to 0 mod P, so no inverse exists.

Function
REQ-012 SHALL compute dout_r = a^(P-2) mod P (Fermat), where a = din_a mod P.
REQ-013 SHALL form a at capture with one conditional subtraction: a = din_a - P if din_a >= P, else din_a.
REQ-014 SHALL run an FSM with states IDLE, SQR, MUL, DONE.
REQ-015 IDLE: in_ready = 1; on in_valid && in_ready, capture a, set acc = a, set bit index = 10, and go to SQR.
REQ-016 SQR: acc <= acc*acc mod P; go to MUL if exponent bit [index] = 1, otherwise decrement index, or go to DONE when index = 0.
REQ-017 MUL: acc <= acc*a mod P; decrement index, or go to DONE when index = 0.
REQ-018 SHALL use exponent constant 2235 = 12'b100010111011, scanned MSB-first with the MSB implicit in acc = a.
REQ-019 Each SQR/MUL step SHALL take exactly one cycle, for 11 squares and 6 multiplies.
REQ-020 Latency SHALL be fixed: out_valid rises exactly 17 rising edges after the accepting edge, for every operand.
REQ-021 DONE: out_valid = 1; dout_r and err_o SHALL hold stable until out_valid && out_ready, then go to IDLE.
REQ-022 in_ready SHALL be 0 in SQR, MUL and DONE; a new operand is never accepted in the cycle of the output handshake.
REQ-023 out_valid SHALL be 0 outside DONE.
REQ-024 Zero operand (din_a = 0 or din_a = 2237): err_o = 1, dout_r = 0, same latency.
REQ-025 Modular multiply: 12x12 product (< 2^23), then Barrett reduction with k = 24 and mu = floor(2^24/P) = 7499, then at most two conditional subtractions; the result SHALL always be < P.
REQ-026 in_valid is ignored outside IDLE, and din_a is not required to stay stable after capture.

Reset
REQ-027 rst_n low SHALL asynchronously force state IDLE, in_ready = 1 (once released), out_valid = 0, dout_r = 0, err_o = 0, acc = 0, index = 0.
REQ-028 Reset asserted mid-computation SHALL abandon the operation with no output handshake; the first accept after release SHALL behave as from cold.

Structure
REQ-029 Shared package SHALL hold P, W, exponent constant 2235, Barrett k = 24, mu = 7499, and the FSM state enum.
REQ-030 SHALL instantiate one combinational sub-module, modmul_2237 (x, y: W bits -> x*y mod P), shared by SQR and MUL through an operand mux.
REQ-031 The top-level FSM, registers and handshake logic SHALL total 120-400 RTL lines together with modmul_2237.

Verification
REQ-032 din_a = 2 accepted -> 17 edges later out_valid = 1, dout_r = 1119, err_o = 0.
REQ-033 din_a = 3 -> dout_r = 746; din_a = 1 -> 1; din_a = 2236 -> 2236.
REQ-034 din_a = 2239 (>= P) -> dout_r = 1119; din_a = 0 and din_a = 2237 -> err_o = 1, dout_r = 0.
REQ-035 out_ready held low 20 cycles in DONE -> dout_r stable and in_ready = 0 throughout, with a single handshake when released.
REQ-036 rst_n pulsed low at cycle 8 of a computation -> out_valid never rises for that operand; the next operand 2 returns 1119 with latency 17.
REQ-037 Exhaustive sweep of din_a = 1..2236 -> (din_a*dout_r) mod 2237 = 1 for every operand; log EQUAL/ERROR per value to a results file.
